// File: rtl/cpu_clock_ctrl_if.sv
// Operator-side bundle for the debug clock controller: raw switches/button, PC feedback,
// and the generated processor clock with its status.
interface cpu_clock_ctrl_if;
  logic        step_n;
  logic        run;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  pc;
  logic        cpu_clk;
  logic        halted;
  logic        busy;
  logic [15:0] cycle_count;

  modport master (
    output step_n, run, bp_en, bp_addr, pc,
    input  cpu_clk, halted, busy, cycle_count
  );

  modport slave (
    input  step_n, run, bp_en, bp_addr, pc,
    output cpu_clk, halted, busy, cycle_count
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Processor clock generator: single-step from a debounced key or free-run at a divided rate,
// with a PC-low-byte breakpoint that halts run mode and a 16-bit pulse counter.
module cpu_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned PULSE_HI        = 4
) (
  input logic             clk,
  input logic             rst,
  cpu_clock_ctrl_if.slave bus
);
  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DivW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int unsigned PhW  = (PULSE_HI > 1) ? $clog2(PULSE_HI) : 1;

  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(PULSE_HI - 1);

  typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

  logic [1:0]      step_n_sync_q, run_sync_q, bp_en_sync_q;
  logic [7:0]      bp_addr_s1_q, bp_addr_s2_q;
  logic            step_db_q, step_db_d, step_db_prev_q;
  logic            run_db_q, run_db_d, run_db_prev_q;
  logic [DbW-1:0]  step_cnt_q, step_cnt_d, run_cnt_q, run_cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic [PhW-1:0]  ph_q, ph_d;
  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic            halted_q, halted_d;
  logic            cpu_clk_q;
  logic [15:0]     cycle_count_q, cycle_count_d;

  logic step_n_s, run_s, bp_en_s;
  logic step_press, run_fall, run_en, tick;

  assign step_n_s   = step_n_sync_q[1];
  assign run_s      = run_sync_q[1];
  assign bp_en_s    = bp_en_sync_q[1];
  assign step_press = step_db_prev_q & ~step_db_q;
  assign run_fall   = run_db_prev_q & ~run_db_q;
  assign run_en     = run_db_q & ~halted_q;
  assign tick       = run_en && (div_q == DivLast);

  always_comb begin
    step_db_d  = step_db_q;
    step_cnt_d = '0;
    if (step_n_s != step_db_q) begin
      if (step_cnt_q == DbLast) step_db_d = step_n_s;
      else                      step_cnt_d = step_cnt_q + 1'b1;
    end
    run_db_d  = run_db_q;
    run_cnt_d = '0;
    if (run_s != run_db_q) begin
      if (run_cnt_q == DbLast) run_db_d = run_s;
      else                     run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_comb begin
    div_d         = (!run_en || tick) ? '0 : div_q + 1'b1;
    state_d       = state_q;
    ph_d          = ph_q;
    pending_d     = pending_q;
    halted_d      = halted_q;
    cycle_count_d = cycle_count_q;
    unique case (state_q)
      StIdle: begin
        // Pending, press and tick all collapse into one pulse; a coincident press is absorbed.
        if (pending_q || step_press || tick) begin
          state_d       = StHi;
          ph_d          = '0;
          pending_d     = 1'b0;
          cycle_count_d = cycle_count_q + 16'd1;
        end
      end
      StHi: begin
        if (step_press) pending_d = 1'b1;
        if (ph_q == PhLast) begin
          state_d = StLo;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StLo: begin
        if (step_press) pending_d = 1'b1;
        if (ph_q == PhLast) begin
          state_d = StIdle;
          ph_d    = '0;
          if (bp_en_s && run_db_q && (bus.pc == bp_addr_s2_q)) halted_d = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (run_fall) halted_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_n_sync_q  <= 2'b11;
      run_sync_q     <= 2'b00;
      bp_en_sync_q   <= 2'b00;
      bp_addr_s1_q   <= '0;
      bp_addr_s2_q   <= '0;
      step_db_q      <= 1'b1;
      step_db_prev_q <= 1'b1;
      run_db_q       <= 1'b0;
      run_db_prev_q  <= 1'b0;
      step_cnt_q     <= '0;
      run_cnt_q      <= '0;
      div_q          <= '0;
      ph_q           <= '0;
      state_q        <= StIdle;
      pending_q      <= 1'b0;
      halted_q       <= 1'b0;
      cpu_clk_q      <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      step_n_sync_q  <= {step_n_sync_q[0], bus.step_n};
      run_sync_q     <= {run_sync_q[0], bus.run};
      bp_en_sync_q   <= {bp_en_sync_q[0], bus.bp_en};
      bp_addr_s1_q   <= bus.bp_addr;
      bp_addr_s2_q   <= bp_addr_s1_q;
      step_db_q      <= step_db_d;
      step_db_prev_q <= step_db_q;
      run_db_q       <= run_db_d;
      run_db_prev_q  <= run_db_q;
      step_cnt_q     <= step_cnt_d;
      run_cnt_q      <= run_cnt_d;
      div_q          <= div_d;
      ph_q           <= ph_d;
      state_q        <= state_d;
      pending_q      <= pending_d;
      halted_q       <= halted_d;
      // Registered from next state so cpu_clk is a clean flop output aligned with StHi.
      cpu_clk_q      <= (state_d == StHi);
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign bus.cpu_clk     = cpu_clk_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.halted      = halted_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: step-press vector table plus hand-written reset,
// double-press, run, breakpoint and counter-wrap sequences.
module tb_cpu_clock_ctrl;
  localparam int unsigned DebCycles = 4;
  localparam int unsigned RunDiv    = 20;
  localparam int unsigned PulseHi   = 2;

  typedef struct {
    string name;
    int    low_cycles;
    int    pulses;
  } step_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_clock_ctrl_if bus ();

  cpu_clock_ctrl #(
    .DEBOUNCE_CYCLES(DebCycles),
    .RUN_DIV        (RunDiv),
    .PULSE_HI       (PulseHi)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rises = 0;
  int hi_len = 0;
  int rise_base = 0;
  int exp_cnt = 0;
  bit prev_clk = 1'b0;
  bit width_en = 1'b1;
  bit pc_adv = 1'b0;
  int rise_t[$];

  // pc follows issued pulses: +4 on each cpu_clk rise while pc_adv is set.
  assign bus.pc = pc_adv ? 8'((rises - rise_base) * 4) : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.cpu_clk && !prev_clk) begin
      rises++;
      rise_t.push_back(cyc);
    end
    if (bus.cpu_clk) begin
      hi_len++;
    end else if (prev_clk) begin
      if (width_en) check("pulse_high_width", hi_len, PulseHi);
      hi_len = 0;
    end
    prev_clk = bus.cpu_clk;
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int low);
    bus.step_n = 1'b0;
    tick_n(low);
    bus.step_n = 1'b1;
  endtask

  task automatic wait_high(input string name);
    int k = 0;
    while (!bus.cpu_clk && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.cpu_clk, 1);
    check({name, "_busy"}, bus.busy, 1);
  endtask

  step_vec_t vecs[6];

  initial begin
    int r0;
    int q0;
    vecs[0] = '{"glitch1", 1, 0};
    vecs[1] = '{"glitch2", 2, 0};
    vecs[2] = '{"glitch3", 3, 0};
    vecs[3] = '{"press4", 4, 1};
    vecs[4] = '{"press10", 10, 1};
    vecs[5] = '{"press6", 6, 1};

    bus.step_n  = 1'b1;
    bus.run     = 1'b0;
    bus.bp_en   = 1'b0;
    bus.bp_addr = 8'h00;
    rst = 1'b1;
    tick_n(3);
    check("rst_cpu_clk", bus.cpu_clk, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_count", bus.cycle_count, 0);
    rst = 1'b0;
    tick_n(5);

    // Reset landing in the middle of a high phase aborts the pulse uncounted.
    r0 = rises;
    press(6);
    wait_high("mid_hi_reached");
    width_en = 1'b0;
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    check("midrst_cpu_clk", bus.cpu_clk, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_halted", bus.halted, 0);
    check("midrst_count", bus.cycle_count, 0);
    tick_n(30);
    width_en = 1'b1;
    check("midrst_no_more_pulses", rises - r0, 1);
    exp_cnt = 0;

    for (int i = 0; i < 6; i++) begin
      r0 = rises;
      press(vecs[i].low_cycles);
      tick_n(25);
      exp_cnt += vecs[i].pulses;
      check({vecs[i].name, "_pulses"}, rises - r0, vecs[i].pulses);
      check({vecs[i].name, "_count"}, bus.cycle_count, exp_cnt);
    end

    // Two extra press strobes during one high phase: one pending, one dropped.
    r0 = rises;
    q0 = rise_t.size();
    press(6);
    wait_high("dbl_first_hi");
    force dut.step_press = 1'b1;
    tick_n(2);
    release dut.step_press;
    tick_n(25);
    exp_cnt += 2;
    check("dbl_pulses", rises - r0, 2);
    check("dbl_count", bus.cycle_count, exp_cnt);
    if (rise_t.size() >= q0 + 2) check("dbl_back_to_back", rise_t[q0+1] - rise_t[q0], 2 * PulseHi + 1);
    else check("dbl_rise_log", rise_t.size(), q0 + 2);

    // Run mode: pulses at cycles 26, 46, ... 206 after run rises; divider idle by 216.
    r0 = rises;
    q0 = rise_t.size();
    bus.run = 1'b1;
    tick_n(210);
    bus.run = 1'b0;
    tick_n(30);
    exp_cnt += 10;
    check("run_pulses", rises - r0, 10);
    check("run_count", bus.cycle_count, exp_cnt);
    check("run_not_halted", bus.halted, 0);
    for (int i = q0 + 1; i < rise_t.size(); i++) check("run_spacing", rise_t[i] - rise_t[i-1], RunDiv);

    // Breakpoint at 0x0C: pulses 1..3 leave pc at 4, 8, 0x0C; halt after the third.
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    rise_base = rises;
    pc_adv = 1'b1;
    bus.bp_en = 1'b1;
    bus.bp_addr = 8'h0C;
    r0 = rises;
    bus.run = 1'b1;
    tick_n(150);
    check("bp_halted", bus.halted, 1);
    check("bp_count", bus.cycle_count, 3);
    check("bp_pulses", rises - r0, 3);
    press(6);
    tick_n(25);
    check("bp_step_pulses", rises - r0, 4);
    check("bp_step_count", bus.cycle_count, 4);
    check("bp_step_keeps_halt", bus.halted, 1);
    bus.run = 1'b0;
    tick_n(15);
    check("bp_run_off_clears", bus.halted, 0);
    tick_n(40);
    check("bp_no_more_pulses", rises - r0, 4);
    pc_adv = 1'b0;
    bus.bp_en = 1'b0;

    // Counter wraps from 0xFFFF to 0.
    force dut.cycle_count_q = 16'hFFFF;
    tick_n(1);
    release dut.cycle_count_q;
    r0 = rises;
    press(6);
    tick_n(20);
    check("wrap_count", bus.cycle_count, 0);
    check("wrap_pulses", rises - r0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
